alu_op_sequencer: RTL and testbench
===================================

# alu_op_sequencer

Parametrised, registered successor to the combinational ALU control decoder. It sits between the decode stage and the ALU. It accepts {opcode, funct} through a valid/ready handshake and maps each opcode class to an ALU operation code. Multi-cycle operations (MUL/DIV) are held in a BUSY state for a configurable latency before the result operation is presented downstream. All outputs are registered; only the handshake ready path is combinational.

## Interface
Parameters:
- OPW, 5, opcode width
- FW, 5, funct / operation width
- MC_LAT, 4, cycles a multi-cycle op occupies the ALU (legal range 1..255)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  synchronous abort; returns to IDLE and drops any held op
- in_valid  in  1  opcode/funct valid
- in_ready  out  1  sequencer can accept this cycle
- opcode  in  OPW  instruction opcode
- funct  in  FW  instruction funct field
- out_valid  out  1  operation valid to ALU
- out_ready  in  1  ALU consumes operation
- operation  out  FW  ALU operation code
- illegal  out  1  qualifies out_valid: opcode not recognised
- mc_busy  out  1  multi-cycle op in progress

## Operation
Decode mapping:
- ART, LOG, CRY → funct
- IMM, ST, LD → IMMED
- any other opcode → 0, with illegal=1

The decoded op is multi-cycle when its opcode is ART and funct ∈ {OP_MUL, OP_DIV}.

States:
- IDLE: in_ready=1, out_valid=0. On accept (in_valid & in_ready):
  - operation and illegal are registered.
  - Multi-cycle op → BUSY with cnt=MC_LAT-1.
  - Otherwise → HOLD.
- BUSY: in_ready=0, mc_busy=1.
  - cnt decrements each cycle.
  - When cnt==0 → HOLD.
- HOLD: out_valid=1, operation/illegal stable.
  - in_ready = out_ready, so the next op is accepted in the same cycle as the handoff.
  - out_ready & in_valid → next state chosen by the new op.
  - out_ready & !in_valid → IDLE.
  - !out_ready → stay in HOLD.

Boundary rules:
- flush has priority over every transition and any accept in the same cycle. Next cycle: IDLE, out_valid=0, mc_busy=0. operation and illegal keep their last value (don't-care).
- rst mid-BUSY or mid-HOLD: the op is discarded and nothing is emitted afterwards.
- Counter width is $clog2(MC_LAT+1); it is never decremented below 0.
- operation and illegal change only on accept.

## Timing
- Reset values: out_valid=0, operation=0, illegal=0, mc_busy=0; state=IDLE; cnt=0. in_ready=1 once rst deasserts.
- Single-cycle op accepted in cycle t → out_valid in cycle t+1.
- Multi-cycle op accepted in cycle t:
  - mc_busy for cycles t+1..t+MC_LAT.
  - out_valid in cycle t+1+MC_LAT.
- Back-to-back single-cycle ops with out_ready held at 1 give a throughput of 1 op/cycle.
- The only combinational input→output path is out_ready → in_ready.

## Configuration
- ALU_ILLEGAL_TRAP_EN
  - Defined: unknown opcodes raise illegal=1 alongside operation=0.
  - Undefined: illegal is tied 0, and unknown opcodes pass as operation=0 (NOP), as the predecessor did.
- Handshake and timing are identical in both builds.

## Structure
- Package alu_ctrl_pkg holds:
  - opcode constants ART, LOG, CRY, IMM, ST, LD
  - IMMED
  - OP_MUL=5'd10, OP_DIV=5'd11
  - state enum {IDLE, BUSY, HOLD}
- One combinational sub-module, alu_op_decode, maps (opcode, funct) → (operation, illegal, is_mc). The sequencer wraps it with the FSM, counter and output registers.

## Test plan
- Reset: assert rst asynchronously mid-cycle → all outputs 0 immediately; in_ready=1 after release.
- LOG with funct=5'd3, out_ready=1 → out_valid next cycle, operation=5'd3, illegal=0.
- ST with funct=5'd7 → operation=IMMED. Then hold out_ready=0 for 3 cycles → operation stays stable, in_ready=0, no new accept.
- ART with funct=OP_MUL and MC_LAT=4 → mc_busy high for 4 cycles, out_valid on cycle 5, in_ready=0 throughout BUSY. An ART/5'd1 then waits and issues right after.
- Stream 8 single-cycle ops with out_ready=1 → 8 consecutive out_valid cycles in order, no bubbles. Then opcode 5'd31 → illegal=1 with the macro defined, 0 without.
- flush during BUSY at cnt=2 → next cycle IDLE, mc_busy=0, out_valid never asserts for the flushed op.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared constants and state type for the ALU operation sequencer.
package alu_ctrl_pkg;

  localparam logic [4:0] ART = 5'd1;
  localparam logic [4:0] LOG = 5'd2;
  localparam logic [4:0] CRY = 5'd3;
  localparam logic [4:0] IMM = 5'd4;
  localparam logic [4:0] ST  = 5'd5;
  localparam logic [4:0] LD  = 5'd6;

  localparam logic [4:0] IMMED  = 5'd2;
  localparam logic [4:0] OP_MUL = 5'd10;
  localparam logic [4:0] OP_DIV = 5'd11;

  typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_e;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode/funct to ALU operation decoder.
// ALU_ILLEGAL_TRAP_EN: when defined, unknown opcodes raise illegal.
module alu_op_decode
  import alu_ctrl_pkg::*;
#(
  parameter int OPW = 5,
  parameter int FW  = 5
) (
  input  logic [OPW-1:0] opcode,
  input  logic [FW-1:0]  funct,
  output logic [FW-1:0]  operation,
  output logic           illegal,
  output logic           is_mc
);

  always_comb begin
    operation = '0;
    illegal   = 1'b0;
    is_mc     = 1'b0;
    if (opcode == OPW'(ART) || opcode == OPW'(LOG) || opcode == OPW'(CRY)) begin
      operation = funct;
    end else if (opcode == OPW'(IMM) || opcode == OPW'(ST) || opcode == OPW'(LD)) begin
      operation = FW'(IMMED);
    end else begin
`ifdef ALU_ILLEGAL_TRAP_EN
      illegal = 1'b1;
`endif
    end
    if (opcode == OPW'(ART) && (funct == FW'(OP_MUL) || funct == FW'(OP_DIV)))
      is_mc = 1'b1;
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Registered ALU op sequencer: decode, multi-cycle BUSY hold-off, output HOLD.
// ALU_ILLEGAL_TRAP_EN (via alu_op_decode): enables illegal-opcode reporting.
module alu_op_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int OPW    = 5,
  parameter int FW     = 5,
  parameter int MC_LAT = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [OPW-1:0] opcode,
  input  logic [FW-1:0]  funct,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [FW-1:0]  operation,
  output logic           illegal,
  output logic           mc_busy
);

  localparam int CW = $clog2(MC_LAT + 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [FW-1:0] operation_q, operation_d;
  logic          illegal_q, illegal_d;
  logic          out_valid_q, out_valid_d;
  logic          mc_busy_q, mc_busy_d;

  logic [FW-1:0] dec_op;
  logic          dec_ill;
  logic          dec_mc;
  logic          accept;

  alu_op_decode #(.OPW(OPW), .FW(FW)) u_decode (
    .opcode    (opcode),
    .funct     (funct),
    .operation (dec_op),
    .illegal   (dec_ill),
    .is_mc     (dec_mc)
  );

  // HOLD forwards out_ready so a new op can enter on the same cycle as the handoff.
  assign in_ready = (state_q == IDLE) || (state_q == HOLD && out_ready);
  assign accept   = in_valid && in_ready && !flush;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    operation_d = operation_q;
    illegal_d   = illegal_q;
    out_valid_d = out_valid_q;
    mc_busy_d   = mc_busy_q;
    if (flush) begin
      state_d     = IDLE;
      cnt_d       = '0;
      out_valid_d = 1'b0;
      mc_busy_d   = 1'b0;
    end else begin
      if (state_q == BUSY) begin
        if (cnt_q == '0) begin
          state_d     = HOLD;
          out_valid_d = 1'b1;
          mc_busy_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end else if (state_q == HOLD && out_ready && !in_valid) begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
      if (accept) begin
        operation_d = dec_op;
        illegal_d   = dec_ill;
        if (dec_mc) begin
          state_d     = BUSY;
          cnt_d       = CW'(MC_LAT - 1);
          out_valid_d = 1'b0;
          mc_busy_d   = 1'b1;
        end else begin
          state_d     = HOLD;
          out_valid_d = 1'b1;
          mc_busy_d   = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      operation_q <= '0;
      illegal_q   <= 1'b0;
      out_valid_q <= 1'b0;
      mc_busy_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      operation_q <= operation_d;
      illegal_q   <= illegal_d;
      out_valid_q <= out_valid_d;
      mc_busy_q   <= mc_busy_d;
    end
  end

  assign out_valid = out_valid_q;
  assign operation = operation_q;
  assign illegal   = illegal_q;
  assign mc_busy   = mc_busy_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: directed scenarios plus a randomized scoreboard run.
module tb_alu_op_sequencer;
  import alu_ctrl_pkg::*;

  localparam int MC_LAT = 4;

  logic       clk = 1'b0;
  logic       rst, flush, in_valid, out_ready;
  logic [4:0] opcode, funct;
  logic       in_ready, out_valid, illegal, mc_busy;
  logic [4:0] operation;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

`ifdef ALU_ILLEGAL_TRAP_EN
  localparam logic TRAP = 1'b1;
`else
  localparam logic TRAP = 1'b0;
`endif

  alu_op_sequencer #(.OPW(5), .FW(5), .MC_LAT(MC_LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .funct     (funct),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .operation (operation),
    .illegal   (illegal),
    .mc_busy   (mc_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference decode straight from the opcode-class table.
  function automatic void ref_decode(input logic [4:0] opc, input logic [4:0] fn,
                                     output logic [4:0] op, output logic ill, output logic mc);
    op = 5'd0; ill = 1'b0; mc = 1'b0;
    case (opc)
      ART, LOG, CRY: op = fn;
      IMM, ST, LD:   op = IMMED;
      default:       ill = TRAP;
    endcase
    mc = (opc == ART) && (fn == OP_MUL || fn == OP_DIV);
  endfunction

  task automatic test_reset;
    $display("test_reset");
    repeat (2) @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%0b exp=0", out_valid); end
    total++; if (operation !== 5'd0) begin bad++; $display("FAIL rst_operation got=%0d exp=0", operation); end
    total++; if (illegal !== 1'b0) begin bad++; $display("FAIL rst_illegal got=%0b exp=0", illegal); end
    total++; if (mc_busy !== 1'b0) begin bad++; $display("FAIL rst_mc_busy got=%0b exp=0", mc_busy); end
    rst = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%0b exp=1", in_ready); end
    @(negedge clk); in_valid = 1'b1; opcode = ART; funct = OP_MUL; out_ready = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    total++; if (mc_busy !== 1'b1) begin bad++; $display("FAIL rst_pre_busy got=%0b exp=1", mc_busy); end
    @(negedge clk); #2 rst = 1'b1; #1;
    total++; if (mc_busy !== 1'b0) begin bad++; $display("FAIL rst_async_busy got=%0b exp=0", mc_busy); end
    total++; if (operation !== 5'd0) begin bad++; $display("FAIL rst_async_op got=%0d exp=0", operation); end
    @(negedge clk); rst = 1'b0;
    repeat (MC_LAT + 2) begin
      @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_discard got=%0b exp=0", out_valid); end
    end
  endtask

  task automatic test_single;
    $display("test_single: LOG funct=3");
    @(negedge clk); out_ready = 1'b1; in_valid = 1'b1; opcode = LOG; funct = 5'd3;
    @(negedge clk); in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%0b exp=1", out_valid); end
    total++; if (operation !== 5'd3) begin bad++; $display("FAIL single_op got=%0d exp=3", operation); end
    total++; if (illegal !== 1'b0) begin bad++; $display("FAIL single_illegal got=%0b exp=0", illegal); end
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_idle got=%0b exp=0", out_valid); end
  endtask

  task automatic test_hold;
    $display("test_hold: ST funct=7 with stalled out_ready");
    @(negedge clk); out_ready = 1'b0; in_valid = 1'b1; opcode = ST; funct = 5'd7;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL hold_idle_ready got=%0b exp=1", in_ready); end
    @(negedge clk); opcode = LOG; funct = 5'd9;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL hold_valid[%0d] got=%0b exp=1", i, out_valid); end
      total++; if (operation !== IMMED) begin bad++; $display("FAIL hold_op[%0d] got=%0d exp=%0d", i, operation, IMMED); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL hold_ready[%0d] got=%0b exp=0", i, in_ready); end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL hold_release_ready got=%0b exp=1", in_ready); end
    @(negedge clk); in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL hold_next_valid got=%0b exp=1", out_valid); end
    total++; if (operation !== 5'd9) begin bad++; $display("FAIL hold_next_op got=%0d exp=9", operation); end
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL hold_idle got=%0b exp=0", out_valid); end
  endtask

  task automatic test_multicycle;
    $display("test_multicycle: ART MUL then ART funct=1");
    @(negedge clk); out_ready = 1'b1; in_valid = 1'b1; opcode = ART; funct = OP_MUL;
    @(negedge clk); funct = 5'd1;
    for (int k = 0; k < MC_LAT; k++) begin
      #1;
      total++; if (mc_busy !== 1'b1) begin bad++; $display("FAIL mc_busy[%0d] got=%0b exp=1", k, mc_busy); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mc_valid[%0d] got=%0b exp=0", k, out_valid); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL mc_ready[%0d] got=%0b exp=0", k, in_ready); end
      @(negedge clk);
    end
    #1;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL mc_done_valid got=%0b exp=1", out_valid); end
    total++; if (operation !== OP_MUL) begin bad++; $display("FAIL mc_done_op got=%0d exp=%0d", operation, OP_MUL); end
    total++; if (mc_busy !== 1'b0) begin bad++; $display("FAIL mc_done_busy got=%0b exp=0", mc_busy); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mc_done_ready got=%0b exp=1", in_ready); end
    @(negedge clk); in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL mc_follow_valid got=%0b exp=1", out_valid); end
    total++; if (operation !== 5'd1) begin bad++; $display("FAIL mc_follow_op got=%0d exp=1", operation); end
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mc_follow_idle got=%0b exp=0", out_valid); end
  endtask

  task automatic test_back_to_back;
    logic [4:0] pool [6];
    logic [4:0] ex_op [8];
    logic       ex_ill [8];
    logic       mc;
    logic [4:0] fn;
    pool[0] = ART; pool[1] = LOG; pool[2] = CRY; pool[3] = IMM; pool[4] = ST; pool[5] = LD;
    $display("test_back_to_back: 8 single-cycle ops then opcode 31");
    @(negedge clk); out_ready = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      if (i > 0) begin
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid[%0d] got=%0b exp=1", i-1, out_valid); end
        total++; if (operation !== ex_op[i-1]) begin bad++; $display("FAIL b2b_op[%0d] got=%0d exp=%0d", i-1, operation, ex_op[i-1]); end
        total++; if (illegal !== ex_ill[i-1]) begin bad++; $display("FAIL b2b_ill[%0d] got=%0b exp=%0b", i-1, illegal, ex_ill[i-1]); end
      end
      if (i < 8) begin
        opcode = pool[$urandom_range(0, 5)];
        do fn = 5'($urandom_range(0, 31)); while (fn == OP_MUL || fn == OP_DIV);
        funct = fn;
        in_valid = 1'b1;
        ref_decode(opcode, funct, ex_op[i], ex_ill[i], mc);
        $display("  op[%0d] opcode=%0d funct=%0d exp_operation=%0d", i, opcode, funct, ex_op[i]);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    in_valid = 1'b1; opcode = 5'd31; funct = 5'($urandom_range(0, 31));
    @(negedge clk); in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL unk_valid got=%0b exp=1", out_valid); end
    total++; if (operation !== 5'd0) begin bad++; $display("FAIL unk_op got=%0d exp=0", operation); end
    total++; if (illegal !== TRAP) begin bad++; $display("FAIL unk_illegal got=%0b exp=%0b", illegal, TRAP); end
    @(negedge clk);
  endtask

  task automatic test_flush;
    $display("test_flush: ART DIV flushed at cnt=2");
    @(negedge clk); out_ready = 1'b1; in_valid = 1'b1; opcode = ART; funct = OP_DIV;
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; opcode = LOG; funct = 5'd4;
    @(negedge clk); flush = 1'b0; in_valid = 1'b0;
    #1;
    total++; if (mc_busy !== 1'b0) begin bad++; $display("FAIL flush_busy got=%0b exp=0", mc_busy); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%0b exp=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_ready got=%0b exp=1", in_ready); end
    repeat (MC_LAT + 2) begin
      @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_no_emit got=%0b exp=0", out_valid); end
    end
  endtask

  // One op in flight at most: an empty scoreboard means the sequencer is free.
  task automatic test_random;
    logic       have = 1'b0;
    logic [4:0] q_op;
    logic       q_ill, q_mc;
    int         q_acc = 0;
    logic       exp_valid, exp_busy, exp_rdy;
    logic [4:0] pool [8];
    int         handoffs = 0;
    pool[0] = ART; pool[1] = ART; pool[2] = LOG; pool[3] = CRY;
    pool[4] = IMM; pool[5] = ST;  pool[6] = LD;  pool[7] = 5'd0;
    $display("test_random: 400 cycles");
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      exp_valid = have && (cyc >= q_acc + 1 + (q_mc ? MC_LAT : 0));
      exp_busy  = have && q_mc && (cyc <= q_acc + MC_LAT);
      total++; if (out_valid !== exp_valid) begin bad++; $display("FAIL rnd_valid cyc=%0d got=%0b exp=%0b", cyc, out_valid, exp_valid); end
      total++; if (mc_busy !== exp_busy) begin bad++; $display("FAIL rnd_busy cyc=%0d got=%0b exp=%0b", cyc, mc_busy, exp_busy); end
      if (exp_valid) begin
        total++; if (operation !== q_op) begin bad++; $display("FAIL rnd_op cyc=%0d got=%0d exp=%0d", cyc, operation, q_op); end
        total++; if (illegal !== q_ill) begin bad++; $display("FAIL rnd_ill cyc=%0d got=%0b exp=%0b", cyc, illegal, q_ill); end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = 1'($urandom_range(0, 1));
      opcode    = pool[$urandom_range(0, 7)];
      if (opcode == 5'd0) opcode = 5'($urandom_range(0, 31));
      funct     = ($urandom_range(0, 2) == 0) ? (($urandom_range(0, 1) != 0) ? OP_MUL : OP_DIV)
                                              : 5'($urandom_range(0, 31));
      #1;
      exp_rdy = !have || (exp_valid && out_ready);
      total++; if (in_ready !== exp_rdy) begin bad++; $display("FAIL rnd_ready cyc=%0d got=%0b exp=%0b", cyc, in_ready, exp_rdy); end
      if (exp_valid && out_ready) begin
        have = 1'b0;
        handoffs++;
      end
      if (in_valid && exp_rdy) begin
        have  = 1'b1;
        q_acc = cyc;
        ref_decode(opcode, funct, q_op, q_ill, q_mc);
      end
    end
    in_valid = 1'b0;
    $display("  random handoffs=%0d", handoffs);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    opcode = 5'd0; funct = 5'd0;
    test_reset;
    test_single;
    test_hold;
    test_multicycle;
    test_back_to_back;
    test_flush;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
